trap_controller: RTL and testbench

//  Parametrised M-mode trap controller; successor to the single-cycle exception controller.
//  - Prioritises sync exceptions and masked level interrupts.
//  - Owns mstatus.MIE/MPIE, mie, mip, mtvec, mepc, mcause, mtval.
//  - Sequences trap entry and mret with a flush/drain/redirect FSM.
//  - Sits beside the pipeline control unit; drives PC redirect into fetch.

---
 rtl/trap_controller_pkg.sv | 31 +++
 rtl/trap_controller_if.sv | 40 ++++
 rtl/trap_controller_prio_enc.sv | 47 ++++
 rtl/trap_controller.sv | 161 ++++++++++++++++
 tb/tb_trap_controller.sv | 386 ++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/trap_controller_pkg.sv
// Shared constants, state encoding and cause codes for the M-mode trap controller.
// Build option TRAP_VECTORED_EN makes mtvec[0] writable so async traps can be vectored.
package trap_pkg;

  localparam logic [11:0] CSR_MSTATUS = 12'h300;
  localparam logic [11:0] CSR_MIE     = 12'h304;
  localparam logic [11:0] CSR_MTVEC   = 12'h305;
  localparam logic [11:0] CSR_MEPC    = 12'h341;
  localparam logic [11:0] CSR_MCAUSE  = 12'h342;
  localparam logic [11:0] CSR_MTVAL   = 12'h343;
  localparam logic [11:0] CSR_MIP     = 12'h344;

  localparam int MSTATUS_MIE_BIT  = 3;
  localparam int MSTATUS_MPIE_BIT = 7;

  // Writable bits of mtvec[1:0]; bit 1 always reads 0, bit 0 is MODE when vectoring exists.
`ifdef TRAP_VECTORED_EN
  localparam logic [1:0] MTVEC_LOW_MASK = 2'b01;
`else
  localparam logic [1:0] MTVEC_LOW_MASK = 2'b00;
`endif

  typedef enum logic [1:0] {IDLE, DRAIN, REDIRECT} trap_state_e;

  localparam logic [5:0] EXC_BREAKPOINT = 6'd3;
  localparam logic [5:0] EXC_ECALL_M    = 6'd11;
  localparam logic [5:0] IRQ_MSI        = 6'd3;
  localparam logic [5:0] IRQ_MTI        = 6'd7;
  localparam logic [5:0] IRQ_MEI        = 6'd11;

endpackage

// File: rtl/trap_controller_if.sv
// Pipeline-facing bundle of the trap controller: trap requests, CSR port, redirect and status.
interface trap_controller_if #(
  parameter int N       = 64,
  parameter int NUM_EXC = 16,
  parameter int NUM_IRQ = 16
);
  logic [NUM_EXC-1:0] exceptSignal;
  logic [N-1:0]       excTval;
  logic [N-1:0]       PC_X;
  logic [N-1:0]       PC_next;
  logic [NUM_IRQ-1:0] irqIn;
  logic               mretIn;
  logic               pipeDrained;
  logic [11:0]        CSR_addr;
  logic [N-1:0]       CSR_In;
  logic               CSR_WriteEnable;
  logic [N-1:0]       CSR_ReadData;
  logic               flush;
  logic               redirectValid;
  logic [N-1:0]       redirectPC;
  logic               busy;
  logic [N-1:0]       mcause;
  logic [N-1:0]       mepc;
  logic [N-1:0]       mtvec;
  logic               mstatus_MIE;

  modport slave (
    input  exceptSignal, excTval, PC_X, PC_next, irqIn, mretIn, pipeDrained,
           CSR_addr, CSR_In, CSR_WriteEnable,
    output CSR_ReadData, flush, redirectValid, redirectPC, busy,
           mcause, mepc, mtvec, mstatus_MIE
  );

  modport master (
    output exceptSignal, excTval, PC_X, PC_next, irqIn, mretIn, pipeDrained,
           CSR_addr, CSR_In, CSR_WriteEnable,
    input  CSR_ReadData, flush, redirectValid, redirectPC, busy,
           mcause, mepc, mtvec, mstatus_MIE
  );
endinterface

// File: rtl/trap_controller_prio_enc.sv
// Trap priority encoder: exceptions (lowest index) beat interrupts (11, 3, 7, then lowest index).
module trap_prio_enc
  import trap_pkg::*;
#(
  parameter int NUM_EXC = 16,
  parameter int NUM_IRQ = 16
) (
  input  logic [NUM_EXC-1:0] exc_i,
  input  logic [NUM_IRQ-1:0] irq_i,
  output logic               valid_o,
  output logic               async_o,
  output logic [5:0]         code_o
);

  localparam int HI_PRIO [3] = '{int'(IRQ_MTI), int'(IRQ_MSI), int'(IRQ_MEI)};

  // Later assignments override earlier ones, so sources are visited from lowest to highest priority.
  always_comb begin
    valid_o = 1'b0;
    async_o = 1'b0;
    code_o  = '0;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (irq_i[i] && i != HI_PRIO[0] && i != HI_PRIO[1] && i != HI_PRIO[2]) begin
        valid_o = 1'b1;
        async_o = 1'b1;
        code_o  = 6'(i);
      end
    end
    for (int k = 0; k < 3; k++) begin
      for (int i = 0; i < NUM_IRQ; i++) begin
        if (irq_i[i] && i == HI_PRIO[k]) begin
          valid_o = 1'b1;
          async_o = 1'b1;
          code_o  = 6'(i);
        end
      end
    end
    for (int i = NUM_EXC - 1; i >= 0; i--) begin
      if (exc_i[i]) begin
        valid_o = 1'b1;
        async_o = 1'b0;
        code_o  = 6'(i);
      end
    end
  end

endmodule

// File: rtl/trap_controller.sv
// M-mode trap controller: owns the trap CSRs and sequences trap entry / mret as IDLE->DRAIN->REDIRECT.
// Build option TRAP_VECTORED_EN (see trap_pkg) enables vectored mtvec mode.
module trap_controller
  import trap_pkg::*;
#(
  parameter int N       = 64,
  parameter int NUM_EXC = 16,
  parameter int NUM_IRQ = 16
) (
  input  logic             clk,
  input  logic             reset,
  trap_controller_if.slave bus
);

  trap_state_e        state_q, state_d;
  logic               mstatusMie_q, mstatusMie_d;
  logic               mstatusMpie_q, mstatusMpie_d;
  logic [NUM_IRQ-1:0] mieReg_q, mieReg_d;
  logic [NUM_IRQ-1:0] mip_q, mip_d;
  logic [N-1:0]       mtvec_q, mtvec_d;
  logic [N-1:0]       mepc_q, mepc_d;
  logic [N-1:0]       mcause_q, mcause_d;
  logic [N-1:0]       mtval_q, mtval_d;
  logic               isMret_q, isMret_d;

  logic               trapValid, trapAsync;
  logic [5:0]         trapCode;
  logic [NUM_IRQ-1:0] eligibleIrq;
  logic               idle, takeTrap, takeMret, csrWe;
  logic [N-1:0]       trapTarget, csrRead;

  assign eligibleIrq = mip_q & mieReg_q & {NUM_IRQ{mstatusMie_q}};

  trap_prio_enc #(.NUM_EXC(NUM_EXC), .NUM_IRQ(NUM_IRQ)) u_prio (
    .exc_i   (bus.exceptSignal),
    .irq_i   (eligibleIrq),
    .valid_o (trapValid),
    .async_o (trapAsync),
    .code_o  (trapCode)
  );

  // Reset is folded into the trap decision so flush stays low while reset is held.
  assign idle     = (state_q == IDLE);
  assign takeTrap = idle && trapValid && !reset;
  assign takeMret = idle && !trapValid && bus.mretIn && !reset;
  assign csrWe    = idle && bus.CSR_WriteEnable;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:     if (takeTrap) state_d = DRAIN;
                else if (takeMret) state_d = REDIRECT;
      DRAIN:    if (bus.pipeDrained) state_d = REDIRECT;
      REDIRECT: state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  assign trapTarget = {mtvec_q[N-1:2], 2'b00} +
                      ((mtvec_q[0] && mcause_q[N-1]) ? {{(N-8){1'b0}}, mcause_q[5:0], 2'b00} : '0);

  always_comb begin
    bus.flush         = takeTrap;
    bus.busy          = !idle;
    bus.redirectValid = (state_q == REDIRECT);
    bus.redirectPC    = '0;
    if (state_q == REDIRECT) bus.redirectPC = isMret_q ? mepc_q : trapTarget;
  end

  // Software writes are applied first; trap entry / mret then override the registers they own.
  always_comb begin
    mstatusMie_d  = mstatusMie_q;
    mstatusMpie_d = mstatusMpie_q;
    mieReg_d      = mieReg_q;
    mip_d         = bus.irqIn;
    mtvec_d       = mtvec_q;
    mepc_d        = mepc_q;
    mcause_d      = mcause_q;
    mtval_d       = mtval_q;
    isMret_d      = isMret_q;
    if (csrWe) begin
      case (bus.CSR_addr)
        CSR_MSTATUS: begin
          mstatusMie_d  = bus.CSR_In[MSTATUS_MIE_BIT];
          mstatusMpie_d = bus.CSR_In[MSTATUS_MPIE_BIT];
        end
        CSR_MIE:    mieReg_d = bus.CSR_In[NUM_IRQ-1:0];
        CSR_MTVEC:  mtvec_d  = {bus.CSR_In[N-1:2], bus.CSR_In[1:0] & MTVEC_LOW_MASK};
        CSR_MEPC:   mepc_d   = {bus.CSR_In[N-1:2], 2'b00};
        CSR_MCAUSE: mcause_d = bus.CSR_In;
        CSR_MTVAL:  mtval_d  = bus.CSR_In;
        default: ;
      endcase
    end
    if (takeTrap) begin
      mepc_d        = trapAsync ? {bus.PC_next[N-1:2], 2'b00} : {bus.PC_X[N-1:2], 2'b00};
      mcause_d      = {trapAsync, {(N-7){1'b0}}, trapCode};
      mtval_d       = trapAsync ? '0 : bus.excTval;
      mstatusMpie_d = mstatusMie_q;
      mstatusMie_d  = 1'b0;
      isMret_d      = 1'b0;
    end else if (takeMret) begin
      mstatusMie_d  = mstatusMpie_q;
      mstatusMpie_d = 1'b1;
      isMret_d      = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mstatusMie_q  <= 1'b0;
      mstatusMpie_q <= 1'b0;
      mieReg_q      <= '0;
      mip_q         <= '0;
      mtvec_q       <= '0;
      mepc_q        <= '0;
      mcause_q      <= '0;
      mtval_q       <= '0;
      isMret_q      <= 1'b0;
    end else begin
      mstatusMie_q  <= mstatusMie_d;
      mstatusMpie_q <= mstatusMpie_d;
      mieReg_q      <= mieReg_d;
      mip_q         <= mip_d;
      mtvec_q       <= mtvec_d;
      mepc_q        <= mepc_d;
      mcause_q      <= mcause_d;
      mtval_q       <= mtval_d;
      isMret_q      <= isMret_d;
    end
  end

  always_comb begin
    csrRead = '0;
    case (bus.CSR_addr)
      CSR_MSTATUS: begin
        csrRead[MSTATUS_MIE_BIT]  = mstatusMie_q;
        csrRead[MSTATUS_MPIE_BIT] = mstatusMpie_q;
      end
      CSR_MIE:    csrRead[NUM_IRQ-1:0] = mieReg_q;
      CSR_MTVEC:  csrRead = mtvec_q;
      CSR_MEPC:   csrRead = mepc_q;
      CSR_MCAUSE: csrRead = mcause_q;
      CSR_MTVAL:  csrRead = mtval_q;
      CSR_MIP:    csrRead[NUM_IRQ-1:0] = mip_q;
      default: ;
    endcase
  end

  assign bus.CSR_ReadData = csrRead;
  assign bus.mcause       = mcause_q;
  assign bus.mepc         = mepc_q;
  assign bus.mtvec        = mtvec_q;
  assign bus.mstatus_MIE  = mstatusMie_q;

endmodule

// File: tb/tb_trap_controller.sv
// Testbench for trap_controller: directed scenarios with literal expectations, then random traffic
// checked every cycle against a transaction-level model of the trap CSRs and redirect sequence.
module tb_trap_controller;

  localparam int N  = 64;
  localparam int NE = 16;
  localparam int NI = 16;
`ifdef TRAP_VECTORED_EN
  localparam bit VEC = 1'b1;
  localparam bit [63:0] TVEC_MASK = ~64'h2;
`else
  localparam bit VEC = 1'b0;
  localparam bit [63:0] TVEC_MASK = ~64'h3;
`endif
  localparam int IRQ_ORDER [16] = '{11, 3, 7, 0, 1, 2, 4, 5, 6, 8, 9, 10, 12, 13, 14, 15};
  localparam bit [11:0] ADDRS [8] = '{12'h300, 12'h304, 12'h305, 12'h341, 12'h342, 12'h343, 12'h344, 12'h123};

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  trap_controller_if #(.N(N), .NUM_EXC(NE), .NUM_IRQ(NI)) bus ();
  trap_controller #(.N(N), .NUM_EXC(NE), .NUM_IRQ(NI)) dut (.clk(clk), .reset(reset), .bus(bus));

  int checks = 0;
  int errors = 0;
  bit checkEn = 1'b0;

  // Reference model state: architectural CSRs plus where the current trap/mret sequence stands.
  bit [63:0] mTvec, mEpc, mCause, mTval;
  bit        mMie, mMpie;
  bit [15:0] mMieReg, mMip;
  bit        waitDrain, redirecting, lastWasMret;

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input bit [15:0] exc, input bit [15:0] irq, input bit mret,
                               input bit drained, input bit we, input bit [11:0] addr, input bit [63:0] data);
    bus.exceptSignal    = exc;
    bus.irqIn           = irq;
    bus.mretIn          = mret;
    bus.pipeDrained     = drained;
    bus.CSR_WriteEnable = we;
    bus.CSR_addr        = addr;
    bus.CSR_In          = data;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic csrWrite(input bit [11:0] addr, input bit [63:0] data);
    bus.CSR_WriteEnable = 1'b1;
    bus.CSR_addr        = addr;
    bus.CSR_In          = data;
    tick();
    bus.CSR_WriteEnable = 1'b0;
  endtask

  function automatic bit pickTrap(input bit [15:0] exc, input bit [15:0] elig,
                                  output bit isAsync, output bit [5:0] code);
    isAsync = 1'b0;
    code    = '0;
    for (int i = 0; i < 16; i++) if (exc[i]) begin code = 6'(i); return 1'b1; end
    for (int k = 0; k < 16; k++) if (elig[IRQ_ORDER[k]]) begin
      isAsync = 1'b1;
      code    = 6'(IRQ_ORDER[k]);
      return 1'b1;
    end
    return 1'b0;
  endfunction

  function automatic bit [15:0] modelElig();
    return mMip & mMieReg & {16{mMie}};
  endfunction

  function automatic bit [63:0] modelRead(input bit [11:0] a);
    case (a)
      12'h300: return (64'(mMie) << 3) | (64'(mMpie) << 7);
      12'h304: return 64'(mMieReg);
      12'h305: return mTvec;
      12'h341: return mEpc;
      12'h342: return mCause;
      12'h343: return mTval;
      12'h344: return 64'(mMip);
      default: return 64'h0;
    endcase
  endfunction

  function automatic bit [63:0] modelTarget();
    bit [63:0] base = mTvec & ~64'h3;
    if (lastWasMret) return mEpc;
    if (mTvec[0] && mCause[63]) return base + 64'(mCause[5:0]) * 4;
    return base;
  endfunction

  task automatic modelWrite(input bit [11:0] a, input bit [63:0] d);
    case (a)
      12'h300: begin mMie = d[3]; mMpie = d[7]; end
      12'h304: mMieReg = d[15:0];
      12'h305: mTvec = d & TVEC_MASK;
      12'h341: mEpc = d & ~64'h3;
      12'h342: mCause = d;
      12'h343: mTval = d;
      default: ;
    endcase
  endtask

  task automatic modelStep();
    bit isA, has, oldMie, oldMpie;
    bit [5:0] code;
    bit [15:0] sampledIrq;
    sampledIrq = bus.irqIn;
    if (redirecting) begin
      redirecting = 1'b0;
    end else if (waitDrain) begin
      if (bus.pipeDrained) begin waitDrain = 1'b0; redirecting = 1'b1; end
    end else begin
      has     = pickTrap(bus.exceptSignal, modelElig(), isA, code);
      oldMie  = mMie;
      oldMpie = mMpie;
      if (bus.CSR_WriteEnable) modelWrite(bus.CSR_addr, bus.CSR_In);
      if (has) begin
        mEpc        = (isA ? bus.PC_next : bus.PC_X) & ~64'h3;
        mCause      = {isA, 57'b0, code};
        mTval       = isA ? 64'h0 : bus.excTval;
        mMpie       = oldMie;
        mMie        = 1'b0;
        waitDrain   = 1'b1;
        lastWasMret = 1'b0;
      end else if (bus.mretIn) begin
        mMie        = oldMpie;
        mMpie       = 1'b1;
        redirecting = 1'b1;
        lastWasMret = 1'b1;
      end
    end
    mMip = sampledIrq;
  endtask

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      mTvec = 0; mEpc = 0; mCause = 0; mTval = 0;
      mMie = 0; mMpie = 0; mMieReg = 0; mMip = 0;
      waitDrain = 0; redirecting = 0; lastWasMret = 0;
    end else begin
      modelStep();
    end
  end

  // Per-cycle comparison of every observable output against the model, away from the active edge.
  always @(negedge clk) begin : compare
    bit isA, pend, idle;
    bit [5:0] code;
    if (checkEn && !reset) begin
      idle = !waitDrain && !redirecting;
      pend = pickTrap(bus.exceptSignal, modelElig(), isA, code);
      checkOutput("flush", bus.flush, idle && pend);
      checkOutput("redirectValid", bus.redirectValid, redirecting);
      checkOutput("redirectPC", bus.redirectPC, redirecting ? modelTarget() : 64'h0);
      checkOutput("busy", bus.busy, !idle);
      checkOutput("CSR_ReadData", bus.CSR_ReadData, modelRead(bus.CSR_addr));
      checkOutput("mcause", bus.mcause, mCause);
      checkOutput("mepc", bus.mepc, mEpc);
      checkOutput("mtvec", bus.mtvec, mTvec);
      checkOutput("mstatus_MIE", bus.mstatus_MIE, mMie);
    end
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not finish (errors so far %0d)", errors);
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    applyStimulus(16'h0, 16'h0, 1'b0, 1'b0, 1'b0, 12'h000, 64'h0);
    bus.PC_X = 0; bus.PC_next = 0; bus.excTval = 0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    checkEn = 1'b1;

    @(negedge clk);
    checkOutput("reset busy", bus.busy, 0);
    checkOutput("reset redirectValid", bus.redirectValid, 0);
    checkOutput("reset redirectPC", bus.redirectPC, 0);
    checkOutput("reset mcause", bus.mcause, 0);
    checkOutput("reset mtvec", bus.mtvec, 0);
    checkOutput("reset MIE", bus.mstatus_MIE, 0);

    $display("[TB] test 1: breakpoint exception");
    tick();
    csrWrite(12'h305, 64'h800);
    csrWrite(12'h300, 64'h8);
    bus.PC_X = 64'h100; bus.excTval = 64'hdead; bus.exceptSignal = 16'h0008;
    @(negedge clk);
    checkOutput("t1 flush", bus.flush, 1);
    checkOutput("t1 MIE before", bus.mstatus_MIE, 1);
    tick();
    bus.exceptSignal = 0;
    @(negedge clk);
    checkOutput("t1 flush width", bus.flush, 0);
    checkOutput("t1 busy", bus.busy, 1);
    checkOutput("t1 mcause", bus.mcause, 64'h3);
    checkOutput("t1 model mcause", mCause, 64'h3);
    checkOutput("t1 mepc", bus.mepc, 64'h100);
    checkOutput("t1 MIE after", bus.mstatus_MIE, 0);
    tick(); tick();
    bus.pipeDrained = 1'b1;
    tick();
    bus.pipeDrained = 1'b0;
    @(negedge clk);
    checkOutput("t1 redirectValid", bus.redirectValid, 1);
    checkOutput("t1 redirectPC", bus.redirectPC, 64'h800);
    tick();
    @(negedge clk);
    checkOutput("t1 redirect pulse", bus.redirectValid, 0);
    checkOutput("t1 busy end", bus.busy, 0);

    $display("[TB] test 2: timer interrupt");
    csrWrite(12'h300, 64'h8);
    csrWrite(12'h304, 64'h80);
    csrWrite(12'h305, 64'h801);
    @(negedge clk);
    checkOutput("t2 mtvec", bus.mtvec, VEC ? 64'h801 : 64'h800);
    bus.PC_next = 64'h3006; bus.irqIn = 16'h0080;
    tick();
    @(negedge clk);
    checkOutput("t2 flush", bus.flush, 1);
    tick();
    bus.irqIn = 0;
    @(negedge clk);
    checkOutput("t2 mcause", bus.mcause, 64'h8000_0000_0000_0007);
    checkOutput("t2 mepc", bus.mepc, 64'h3004);
    bus.pipeDrained = 1'b1;
    tick();
    bus.pipeDrained = 1'b0;
    @(negedge clk);
    checkOutput("t2 redirectValid", bus.redirectValid, 1);
    checkOutput("t2 redirectPC", bus.redirectPC, VEC ? 64'h81C : 64'h800);
    tick();

    $display("[TB] test 3: exception beats interrupts, then mret and MEI");
    csrWrite(12'h304, 64'h888);
    csrWrite(12'h300, 64'h8);
    bus.PC_X = 64'h204; bus.irqIn = 16'h0808;
    tick();
    bus.exceptSignal = 16'h0004;
    @(negedge clk);
    checkOutput("t3 flush", bus.flush, 1);
    tick();
    bus.exceptSignal = 0;
    @(negedge clk);
    checkOutput("t3 mcause", bus.mcause, 64'h2);
    checkOutput("t3 mepc", bus.mepc, 64'h204);
    bus.pipeDrained = 1'b1;
    tick();
    bus.pipeDrained = 1'b0;
    @(negedge clk);
    checkOutput("t3 redirectValid", bus.redirectValid, 1);
    tick();
    bus.mretIn = 1'b1;
    @(negedge clk);
    checkOutput("t3 mret no flush", bus.flush, 0);
    tick();
    bus.mretIn = 1'b0;
    @(negedge clk);
    checkOutput("t3 mret redirect", bus.redirectValid, 1);
    checkOutput("t3 mret PC", bus.redirectPC, 64'h204);
    checkOutput("t3 MIE restored", bus.mstatus_MIE, 1);
    bus.PC_next = 64'h4000;
    tick();
    @(negedge clk);
    checkOutput("t3 irq flush", bus.flush, 1);
    tick();
    bus.irqIn = 0;
    @(negedge clk);
    checkOutput("t3 irq mcause", bus.mcause, 64'h8000_0000_0000_000B);
    bus.pipeDrained = 1'b1;
    tick();
    bus.pipeDrained = 1'b0;
    @(negedge clk);
    checkOutput("t3 irq redirectPC", bus.redirectPC, VEC ? 64'h82C : 64'h800);
    tick();

    $display("[TB] test 4: mret to 0x2000");
    csrWrite(12'h341, 64'h2000);
    csrWrite(12'h300, 64'h80);
    bus.mretIn = 1'b1;
    @(negedge clk);
    checkOutput("t4 no flush", bus.flush, 0);
    tick();
    bus.mretIn = 1'b0;
    bus.CSR_addr = 12'h300;
    @(negedge clk);
    checkOutput("t4 redirectValid", bus.redirectValid, 1);
    checkOutput("t4 redirectPC", bus.redirectPC, 64'h2000);
    checkOutput("t4 MIE", bus.mstatus_MIE, 1);
    checkOutput("t4 mstatus", bus.CSR_ReadData, 64'h88);
    tick();

    $display("[TB] test 5: CSR write collides with trap entry");
    bus.PC_X = 64'h1237; bus.excTval = 64'habc; bus.exceptSignal = 16'h0001;
    bus.CSR_WriteEnable = 1'b1; bus.CSR_addr = 12'h341; bus.CSR_In = 64'h55;
    @(negedge clk);
    checkOutput("t5 flush", bus.flush, 1);
    tick();
    bus.exceptSignal = 0;
    bus.CSR_addr = 12'h305; bus.CSR_In = 64'h400;
    @(negedge clk);
    checkOutput("t5 mepc", bus.mepc, 64'h1234);
    tick();
    bus.CSR_WriteEnable = 1'b0;
    @(negedge clk);
    checkOutput("t5 mtvec kept", bus.CSR_ReadData, VEC ? 64'h801 : 64'h800);
    tick();
    bus.CSR_addr = 12'h343;
    bus.pipeDrained = 1'b1;
    @(negedge clk);
    checkOutput("t5 mtval", bus.CSR_ReadData, 64'habc);
    tick();
    bus.pipeDrained = 1'b0;
    @(negedge clk);
    checkOutput("t5 redirectPC", bus.redirectPC, 64'h800);
    tick();

    $display("[TB] test 6: reset during DRAIN");
    bus.PC_X = 64'h500; bus.exceptSignal = 16'h0002;
    tick();
    bus.exceptSignal = 0;
    @(negedge clk);
    checkOutput("t6 busy", bus.busy, 1);
    reset = 1'b1;
    #1;
    checkOutput("t6 busy", bus.busy, 0);
    checkOutput("t6 flush", bus.flush, 0);
    checkOutput("t6 redirectValid", bus.redirectValid, 0);
    checkOutput("t6 redirectPC", bus.redirectPC, 0);
    checkOutput("t6 mcause", bus.mcause, 0);
    checkOutput("t6 mepc", bus.mepc, 0);
    checkOutput("t6 MIE", bus.mstatus_MIE, 0);
    for (int i = 0; i < 8; i++) begin
      bus.CSR_addr = ADDRS[i];
      #1;
      checkOutput("t6 csr read", bus.CSR_ReadData, 0);
    end
    bus.pipeDrained = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checkOutput("t6 no redirect", bus.redirectValid, 0);
    end
    tick();
    bus.pipeDrained = 1'b0;

    $display("[TB] random phase");
    for (int c = 0; c < 3000; c++) begin
      tick();
      bus.exceptSignal = ($urandom_range(0, 19) == 0) ?
                         (16'(1 << $urandom_range(0, 15)) | (($urandom_range(0, 3) == 0) ? 16'($urandom) : 16'h0)) : 16'h0;
      if ($urandom_range(0, 7) == 0) bus.irqIn = 16'($urandom) & 16'($urandom);
      bus.mretIn          = ($urandom_range(0, 11) == 0);
      bus.pipeDrained     = ($urandom_range(0, 2) == 0);
      bus.CSR_WriteEnable = ($urandom_range(0, 4) == 0);
      bus.CSR_addr        = ADDRS[$urandom_range(0, 7)];
      bus.CSR_In          = {$urandom, $urandom};
      bus.PC_X            = {$urandom, $urandom};
      bus.PC_next         = {$urandom, $urandom};
      bus.excTval         = {$urandom, $urandom};
    end
    tick();
    @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
